// File: rtl/pwm_pkg.sv
// Shared types, widths and helpers for the PWM H-bridge driver.
package pwm_pkg;

  localparam int DUTY_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DEAD
  } pwm_state_t;

  // Magnitude of a signed 16-bit request; -32768 saturates to 32767.
  function automatic logic [DUTY_W-1:0] sat_abs16(input logic signed [DUTY_W-1:0] v);
    logic [DUTY_W-1:0] mag;
    if (v == {1'b1, {(DUTY_W-1){1'b0}}}) begin
      mag = {1'b0, {(DUTY_W-1){1'b1}}};
    end else if (v[DUTY_W-1]) begin
      mag = -v;
    end else begin
      mag = v;
    end
    return mag;
  endfunction

endpackage

// File: rtl/pwm_hbridge_driver_if.sv
// Request/status bundle between the PID side and one H-bridge driver channel.
// SLEW_LIMIT_EN adds the slew_step request field.
interface pwm_hbridge_driver_if;
  import pwm_pkg::*;

  logic                     enable;
  logic signed [DUTY_W-1:0] pwm_ref;
  logic        [DUTY_W-1:0] duty_max;
`ifdef SLEW_LIMIT_EN
  logic        [DUTY_W-1:0] slew_step;
`endif
  logic                     pwm_a;
  logic                     pwm_b;
  logic                     dir;
  logic                     period_start;
  logic                     deadtime;

  modport master (
    output enable, pwm_ref, duty_max,
`ifdef SLEW_LIMIT_EN
    output slew_step,
`endif
    input  pwm_a, pwm_b, dir, period_start, deadtime
  );

  modport slave (
    input  enable, pwm_ref, duty_max,
`ifdef SLEW_LIMIT_EN
    input  slew_step,
`endif
    output pwm_a, pwm_b, dir, period_start, deadtime
  );
endinterface

// File: rtl/pwm_period_counter.sv
// PWM period counter: counts 0..PERIOD_CNT-1 while running, held at 0 otherwise.
// period_start is registered so it lines up with the registered PWM legs.
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int PERIOD_CNT = 2500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_run,
  output logic [DUTY_W-1:0] o_cnt,
  output logic              o_boundary,
  output logic              o_period_start
);

  localparam logic [DUTY_W-1:0] LP_LAST = DUTY_W'(PERIOD_CNT - 1);

  logic [DUTY_W-1:0] r_cnt;
  logic              r_period_start;

  // Free-running wrap counter plus start-of-period pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else if (!i_run) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= (r_cnt == '0);
      r_cnt          <= (r_cnt == LP_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt          = r_cnt;
  assign o_boundary     = i_run && (r_cnt == LP_LAST);
  assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_hbridge_driver.sv
// H-bridge PWM driver: edge-aligned PWM, per-period duty buffer, dead-time on reversal.
// SLEW_LIMIT_EN: applied duty ramps by at most slew_step per period; reversals ramp to 0 first.
module pwm_hbridge_driver
  import pwm_pkg::*;
#(
  parameter int PERIOD_CNT   = 2500,
  parameter int DEADTIME_CNT = 50
) (
  input  logic                 clock,
  input  logic                 reset,
  pwm_hbridge_driver_if.slave  bus
);

  localparam logic [DUTY_W-1:0] LP_PERIOD = DUTY_W'(PERIOD_CNT);
  localparam logic [DUTY_W-1:0] LP_DEAD   = DUTY_W'(DEADTIME_CNT);

  pwm_state_t        r_state, w_next;
  logic [DUTY_W-1:0] r_duty, r_dead;
  logic              r_dir, r_pend_dir, r_pwm_a, r_pwm_b;
  logic [DUTY_W-1:0] w_cnt, w_abs, w_ceil, w_mag, w_new_duty;
  logic              w_run, w_boundary, w_period_start;
  logic              w_req_dir, w_rev, w_enter_dead;

  assign w_run = bus.enable && (r_state != IDLE);

  pwm_period_counter #(.PERIOD_CNT(PERIOD_CNT)) u_counter (
    .clock          (clock),
    .reset          (reset),
    .i_run          (w_run),
    .o_cnt          (w_cnt),
    .o_boundary     (w_boundary),
    .o_period_start (w_period_start)
  );

  // Boundary-sample request: saturated magnitude, clamped ceiling, requested direction.
  always_comb begin
    w_abs     = sat_abs16(bus.pwm_ref);
    w_ceil    = (bus.duty_max < LP_PERIOD) ? bus.duty_max : LP_PERIOD;
    w_mag     = (w_abs < w_ceil) ? w_abs : w_ceil;
    w_req_dir = ~bus.pwm_ref[DUTY_W-1];
    w_rev     = (w_req_dir != r_dir) && (w_mag != '0);
  end

`ifdef SLEW_LIMIT_EN
  logic [DUTY_W-1:0] w_goal, w_down_gap;
  logic [DUTY_W:0]   w_up;

  // Reversals slew toward zero in the current direction; DEAD is only entered from zero duty.
  always_comb begin
    w_goal     = w_rev ? '0 : w_mag;
    w_up       = {1'b0, r_duty} + {1'b0, bus.slew_step};
    w_down_gap = r_duty - w_goal;
    if (r_duty < w_goal) begin
      w_new_duty = (w_up > {1'b0, w_goal}) ? w_goal : w_up[DUTY_W-1:0];
    end else begin
      w_new_duty = (w_down_gap > bus.slew_step) ? r_duty - bus.slew_step : w_goal;
    end
  end

  assign w_enter_dead = w_rev && (r_duty == '0);
`else
  assign w_new_duty   = w_mag;
  assign w_enter_dead = w_rev;
`endif

  // Next-state logic; enable low overrides every transition.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.enable) w_next = RUN;
      RUN:     if (w_boundary && w_enter_dead) w_next = DEAD;
      DEAD:    if (r_dead == DUTY_W'(1)) w_next = RUN;
      default: w_next = IDLE;
    endcase
    if (!bus.enable) w_next = IDLE;
  end

  // State register, duty buffer, dead counter, direction and registered legs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_duty     <= '0;
      r_dead     <= '0;
      r_dir      <= 1'b1;
      r_pend_dir <= 1'b1;
      r_pwm_a    <= 1'b0;
      r_pwm_b    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pwm_a <= bus.enable && (r_state == RUN) &&  r_dir && (w_cnt < r_duty);
      r_pwm_b <= bus.enable && (r_state == RUN) && !r_dir && (w_cnt < r_duty);
      if (!bus.enable) begin
        r_duty <= '0;
      end else begin
        unique case (r_state)
          IDLE: r_duty <= '0;
          RUN: begin
            if (w_boundary) begin
              if (w_enter_dead) begin
                r_duty     <= '0;
                r_dead     <= LP_DEAD;
                r_pend_dir <= w_req_dir;
              end else begin
                r_duty <= w_new_duty;
              end
            end
          end
          DEAD: begin
            r_dead <= r_dead - 1'b1;
            if (r_dead == DUTY_W'(1)) r_dir <= r_pend_dir;
          end
          default: r_duty <= '0;
        endcase
      end
    end
  end

  assign bus.pwm_a        = r_pwm_a;
  assign bus.pwm_b        = r_pwm_b;
  assign bus.dir          = r_dir;
  assign bus.period_start = w_period_start;
  assign bus.deadtime     = (r_state == DEAD);

endmodule

// File: tb/tb_pwm_hbridge_driver.sv
// Directed bench for pwm_hbridge_driver with PERIOD_CNT=100, DEADTIME_CNT=10.
module tb_pwm_hbridge_driver;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic overlap_seen = 1'b0;

  always #5 clock = ~clock;

  pwm_hbridge_driver_if bus ();

  pwm_hbridge_driver #(.PERIOD_CNT(100), .DEADTIME_CNT(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always @(negedge clock) if (bus.pwm_a && bus.pwm_b) overlap_seen = 1'b1;

  // Samples n consecutive negedges starting at the current one; ends on the next unsampled negedge.
  task automatic measure(input int n, output int na, output int nb, output int nps, output int ndt);
    na = 0; nb = 0; nps = 0; ndt = 0;
    for (int i = 0; i < n; i++) begin
      na  += int'(bus.pwm_a);
      nb  += int'(bus.pwm_b);
      nps += int'(bus.period_start);
      ndt += int'(bus.deadtime);
      @(negedge clock);
    end
  endtask

  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.period_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.enable = 1'b0; bus.pwm_ref = '0; bus.duty_max = 16'd100;
`ifdef SLEW_LIMIT_EN
    bus.slew_step = 16'hFFFF;
`endif
    repeat (3) @(negedge clock);
    n_cmp++; if (bus.pwm_a !== 1'b0) begin n_bad++; $display("FAIL reset_pwm_a got=%b exp=0", bus.pwm_a); end
    n_cmp++; if (bus.pwm_b !== 1'b0) begin n_bad++; $display("FAIL reset_pwm_b got=%b exp=0", bus.pwm_b); end
    n_cmp++; if (bus.dir !== 1'b1) begin n_bad++; $display("FAIL reset_dir got=%b exp=1", bus.dir); end
    n_cmp++; if (bus.period_start !== 1'b0) begin n_bad++; $display("FAIL reset_ps got=%b exp=0", bus.period_start); end
    n_cmp++; if (bus.deadtime !== 1'b0) begin n_bad++; $display("FAIL reset_dt got=%b exp=0", bus.deadtime); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic;
    int na, nb, nps, ndt; bit ok;
    bus.pwm_ref = 16'sd25; bus.duty_max = 16'd100; bus.enable = 1'b1;
    wait_ps(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_start got=timeout exp=period_start"); end
    measure(100, na, nb, nps, ndt);
    n_cmp++; if (na + nb !== 0) begin n_bad++; $display("FAIL basic_first_period got=%0d exp=0", na + nb); end
    n_cmp++; if (nps !== 1) begin n_bad++; $display("FAIL basic_ps_count got=%0d exp=1", nps); end
    for (int p = 0; p < 2; p++) begin
      measure(100, na, nb, nps, ndt);
      n_cmp++; if (na !== 25) begin n_bad++; $display("FAIL basic_pwm_a got=%0d exp=25", na); end
      n_cmp++; if (nb !== 0) begin n_bad++; $display("FAIL basic_pwm_b got=%0d exp=0", nb); end
      n_cmp++; if (bus.dir !== 1'b1) begin n_bad++; $display("FAIL basic_dir got=%b exp=1", bus.dir); end
    end
  endtask

  task automatic test_reversal;
    int na, nb, nps, ndt, na2, nb2, nps2, ndt2;
    bus.pwm_ref = 16'sd40;
    measure(100, na, nb, nps, ndt);
    measure(20, na, nb, nps, ndt);
    bus.pwm_ref = -16'sd40;
    measure(80, na2, nb2, nps2, ndt2);
    n_cmp++; if (na + na2 !== 40) begin n_bad++; $display("FAIL rev_finish_period got=%0d exp=40", na + na2); end
    measure(100, na, nb, nps, ndt);
    n_cmp++; if (ndt + ndt2 !== 10) begin n_bad++; $display("FAIL rev_deadtime_len got=%0d exp=10", ndt + ndt2); end
    n_cmp++; if (na + nb !== 0) begin n_bad++; $display("FAIL rev_dead_period_legs got=%0d exp=0", na + nb); end
    n_cmp++; if (bus.dir !== 1'b0) begin n_bad++; $display("FAIL rev_dir got=%b exp=0", bus.dir); end
    measure(100, na, nb, nps, ndt);
    n_cmp++; if (nb !== 40) begin n_bad++; $display("FAIL rev_pwm_b got=%0d exp=40", nb); end
    n_cmp++; if (na !== 0 || ndt !== 0) begin n_bad++; $display("FAIL rev_after got=a%0d/dt%0d exp=0/0", na, ndt); end
  endtask

  task automatic test_clamp;
    int na, nb, nps, ndt;
    bus.pwm_ref = -16'sd32768; bus.duty_max = 16'd60;
    measure(100, na, nb, nps, ndt);
    measure(100, na, nb, nps, ndt);
    n_cmp++; if (nb !== 60 || na !== 0) begin n_bad++; $display("FAIL clamp_min got=b%0d/a%0d exp=60/0", nb, na); end
    bus.pwm_ref = 16'sd200; bus.duty_max = 16'd500;
    repeat (2) measure(100, na, nb, nps, ndt);
    measure(100, na, nb, nps, ndt);
    n_cmp++; if (na !== 100 || nb !== 0) begin n_bad++; $display("FAIL clamp_full got=a%0d/b%0d exp=100/0", na, nb); end
    n_cmp++; if (bus.dir !== 1'b1) begin n_bad++; $display("FAIL clamp_dir got=%b exp=1", bus.dir); end
  endtask

  task automatic test_enable_drop;
    int na, nb, nps, ndt; bit ok;
    bus.pwm_ref = -16'sd30; bus.duty_max = 16'd100;
    measure(100, na, nb, nps, ndt);
    n_cmp++; if (bus.deadtime !== 1'b1) begin n_bad++; $display("FAIL en_in_dead got=%b exp=1", bus.deadtime); end
    bus.enable = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.deadtime !== 1'b0 || bus.pwm_a !== 1'b0 || bus.pwm_b !== 1'b0)
      begin n_bad++; $display("FAIL en_drop_outs got=dt%b/a%b/b%b exp=0/0/0", bus.deadtime, bus.pwm_a, bus.pwm_b); end
    n_cmp++; if (dut.u_counter.r_cnt !== 16'd0) begin n_bad++; $display("FAIL en_drop_cnt got=%0d exp=0", dut.u_counter.r_cnt); end
    n_cmp++; if (bus.dir !== 1'b1) begin n_bad++; $display("FAIL en_drop_dir got=%b exp=1", bus.dir); end
    measure(150, na, nb, nps, ndt);
    n_cmp++; if (nps + na + nb + ndt !== 0) begin n_bad++; $display("FAIL idle_activity got=%0d exp=0", nps + na + nb + ndt); end
    bus.enable = 1'b1;
    wait_ps(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL reen_start got=timeout exp=period_start"); end
    measure(100, na, nb, nps, ndt);
    n_cmp++; if (na + nb !== 0) begin n_bad++; $display("FAIL reen_first_duty got=%0d exp=0", na + nb); end
    measure(100, na, nb, nps, ndt);
    measure(100, na, nb, nps, ndt);
    n_cmp++; if (nb !== 30 || bus.dir !== 1'b0) begin n_bad++; $display("FAIL reen_pwm_b got=%0d/dir%b exp=30/0", nb, bus.dir); end
  endtask

  task automatic test_async_reset;
    int na, nb, nps, ndt; bit ok;
    measure(10, na, nb, nps, ndt);
    n_cmp++; if (bus.pwm_b !== 1'b1) begin n_bad++; $display("FAIL areset_pre_b got=%b exp=1", bus.pwm_b); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.pwm_b !== 1'b0 || bus.dir !== 1'b1) begin n_bad++; $display("FAIL areset_b got=%b/dir%b exp=0/1", bus.pwm_b, bus.dir); end
    @(negedge clock);
    reset = 1'b0;
    bus.pwm_ref = 16'sd50;
    wait_ps(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL areset_restart got=timeout exp=period_start"); end
    measure(100, na, nb, nps, ndt);
    measure(100, na, nb, nps, ndt);
    n_cmp++; if (na !== 50) begin n_bad++; $display("FAIL areset_fwd got=%0d exp=50", na); end
    measure(10, na, nb, nps, ndt);
    n_cmp++; if (bus.pwm_a !== 1'b1) begin n_bad++; $display("FAIL areset_pre_a got=%b exp=1", bus.pwm_a); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.pwm_a !== 1'b0) begin n_bad++; $display("FAIL areset_a got=%b exp=0", bus.pwm_a); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.dir !== 1'b1) begin n_bad++; $display("FAIL areset_dir got=%b exp=1", bus.dir); end
  endtask

`ifdef SLEW_LIMIT_EN
  task automatic test_slew;
    int na, nb, nps, ndt; bit ok;
    int exp_d [4] = '{10, 20, 30, 35};
    reset = 1'b1; bus.enable = 1'b1; bus.pwm_ref = '0; bus.duty_max = 16'd100; bus.slew_step = 16'd10;
    @(negedge clock);
    reset = 1'b0;
    wait_ps(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL slew_start got=timeout exp=period_start"); end
    measure(100, na, nb, nps, ndt);
    bus.pwm_ref = 16'sd35;
    measure(100, na, nb, nps, ndt);
    for (int p = 0; p < 4; p++) begin
      measure(100, na, nb, nps, ndt);
      n_cmp++; if (na !== exp_d[p]) begin n_bad++; $display("FAIL slew_step%0d got=%0d exp=%0d", p, na, exp_d[p]); end
    end
  endtask
`endif

  task automatic test_no_overlap;
    n_cmp++; if (overlap_seen !== 1'b0) begin n_bad++; $display("FAIL leg_overlap got=%b exp=0", overlap_seen); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic();
`ifdef SLEW_LIMIT_EN
    test_slew();
`else
    test_reversal();
    test_clamp();
    test_enable_drop();
    test_async_reset();
`endif
    test_no_overlap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
